cpu_core: RTL and testbench

- Single-cycle RV32I-subset processor core: fetches one instruction per clock from an external instruction memory and accesses an external data memory combinationally.
- Executes, writes back and advances the PC on each rising clock edge.
- Sits between a synchronous-write/async-read instruction ROM and data RAM in the top-level SoC.

---
 rtl/cpu_core.sv | 221 ++++++++++++++++++++++
 tb/tb_cpu_core.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// cpu_core: single-cycle RV32I-subset core. One instruction is decoded,
// executed and retired per clock; data memory is accessed combinationally
// through dataAddr/readData/writeData/we.
module cpu_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] readData,
    output logic [31:0] result,
    output logic [31:0] instrAddr,
    output logic [31:0] dataAddr,
    output logic [31:0] writeData,
    output logic        we
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JAL, PC_JALR} pc_sel_e;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

    // Instruction fields
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1_a;
    logic [4:0]  rs2_a;
    logic [4:0]  rd_a;

    // Operands and immediates
    logic signed [31:0] rs1_v;
    logic signed [31:0] rs2_v;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_j;
    logic signed [31:0] imm_u;

    // State
    logic [31:0] rf_q [32];
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] wb_d;
    logic        rf_we_d;

    // Decode controls
    alu_op_e            alu_op;
    pc_sel_e            pc_sel;
    wb_sel_e            wb_sel;
    logic signed [31:0] alu_a;
    logic signed [31:0] alu_b;
    logic signed [31:0] alu_y;
    logic               dec_rf_we;
    logic               dec_mem_we;

    assign opcode = instr[6:0];
    assign rd_a   = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1_a  = instr[19:15];
    assign rs2_a  = instr[24:20];
    assign funct7 = instr[31:25];

    // x0 is hardwired to zero on the read side; its storage entry is never written
    assign rs1_v = (rs1_a == 5'd0) ? 32'sd0 : $signed(rf_q[rs1_a]);
    assign rs2_v = (rs2_a == 5'd0) ? 32'sd0 : $signed(rf_q[rs2_a]);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    assign pc_plus4 = pc_q + 32'd4;

    // Decoder: pick ALU operation/operands, writeback source and PC source;
    // anything unrecognised falls through as a nop with zero ALU operands
    always_comb begin
        alu_op     = ALU_ADD;
        alu_a      = 32'sd0;
        alu_b      = 32'sd0;
        pc_sel     = PC_SEQ;
        wb_sel     = WB_ALU;
        dec_rf_we  = 1'b0;
        dec_mem_we = 1'b0;
        case (opcode)
            OP_R: begin
                alu_a     = rs1_v;
                alu_b     = rs2_v;
                dec_rf_we = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: alu_op = ALU_ADD;
                    10'b0100000_000: alu_op = ALU_SUB;
                    10'b0000000_111: alu_op = ALU_AND;
                    10'b0000000_110: alu_op = ALU_OR;
                    10'b0000000_010: alu_op = ALU_SLT;
                    10'b0000000_001: alu_op = ALU_SLL;
                    10'b0000000_101: alu_op = ALU_SRL;
                    10'b0100000_101: alu_op = ALU_SRA;
                    default: begin
                        alu_a     = 32'sd0;
                        alu_b     = 32'sd0;
                        dec_rf_we = 1'b0;
                    end
                endcase
            end
            OP_IMM: begin
                if (funct3 == 3'b000 || funct3 == 3'b110) begin
                    alu_op    = (funct3 == 3'b110) ? ALU_OR : ALU_ADD;
                    alu_a     = rs1_v;
                    alu_b     = imm_i;
                    dec_rf_we = 1'b1;
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    alu_a     = rs1_v;
                    alu_b     = imm_i;
                    wb_sel    = WB_MEM;
                    dec_rf_we = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    alu_a      = rs1_v;
                    alu_b      = imm_s;
                    dec_mem_we = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000) begin
                    alu_op = ALU_SUB;
                    alu_a  = rs1_v;
                    alu_b  = rs2_v;
                    pc_sel = PC_BRANCH;
                end
            end
            OP_JAL: begin
                alu_b     = imm_j;
                wb_sel    = WB_PC4;
                pc_sel    = PC_JAL;
                dec_rf_we = 1'b1;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    alu_a     = rs1_v;
                    alu_b     = imm_i;
                    wb_sel    = WB_PC4;
                    pc_sel    = PC_JALR;
                    dec_rf_we = 1'b1;
                end
            end
            OP_LUI: begin
                alu_b     = imm_u;
                dec_rf_we = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU: all arithmetic wraps modulo 2^32; shifts use the low five bits of operand b
    always_comb begin
        alu_y = 32'sd0;
        case (alu_op)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = (alu_a < alu_b) ? 32'sd1 : 32'sd0;
            ALU_SLL: alu_y = alu_a << alu_b[4:0];
            ALU_SRL: alu_y = $signed($unsigned(alu_a) >> alu_b[4:0]);
            ALU_SRA: alu_y = alu_a >>> alu_b[4:0];
            default: alu_y = 32'sd0;
        endcase
    end

    // Next PC and writeback value; jalr clears bit 0 of the computed target
    always_comb begin
        pc_d = pc_plus4;
        case (pc_sel)
            PC_BRANCH: if (alu_y == 32'sd0) pc_d = pc_q + imm_b;
            PC_JAL:    pc_d = pc_q + imm_j;
            PC_JALR:   pc_d = {alu_y[31:1], 1'b0};
            default:   pc_d = pc_plus4;
        endcase
        case (wb_sel)
            WB_MEM:  wb_d = readData;
            WB_PC4:  wb_d = pc_plus4;
            default: wb_d = alu_y;
        endcase
        rf_we_d = dec_rf_we && (rd_a != 5'd0);
    end

    // Program counter, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) pc_q <= '0;
        else       pc_q <= pc_d;
    end

    // Register file write port; suppressed while reset is held
    always_ff @(posedge clk) begin
        if (!reset && rf_we_d) rf_q[rd_a] <= wb_d;
    end

    assign result    = alu_y;
    assign dataAddr  = alu_y;
    assign instrAddr = pc_q;
    assign writeData = rs2_v;
    assign we        = dec_mem_we & ~reset;

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed scenarios plus randomized instruction streams checked
// against an instruction-level reference model of the core.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] readData;
    logic [31:0] result;
    logic [31:0] instrAddr;
    logic [31:0] dataAddr;
    logic [31:0] writeData;
    logic        we;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model state and expectations for the current instruction
    logic [31:0] m_rf [32];
    logic [31:0] m_pc;
    logic [31:0] e_res;
    logic [31:0] e_wval;
    logic [31:0] e_npc;
    logic [4:0]  e_rd;
    bit          e_we;
    bit          e_wr;
    bit          e_known;

    cpu_core dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .readData  (readData),
        .result    (result),
        .instrAddr (instrAddr),
        .dataAddr  (dataAddr),
        .writeData (writeData),
        .we        (we)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    // Reference model: what the instruction does architecturally
    function automatic void model_exec(input logic [31:0] ins, input logic [31:0] rdat);
        logic [31:0] a, b, imm_i, imm_s, imm_b, imm_j, imm_u;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        a  = m_rf[ins[19:15]];
        b  = m_rf[ins[24:20]];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        imm_u = {ins[31:12], 12'b0};
        e_rd = ins[11:7];
        e_res = 0; e_known = 0; e_we = 0; e_wr = 0; e_wval = 0;
        e_npc = m_pc + 32'd4;
        case (op)
            7'b0110011: begin
                e_known = 1; e_wr = 1;
                if (f7 == 7'h00 && f3 == 3'd0)      e_res = a + b;
                else if (f7 == 7'h20 && f3 == 3'd0) e_res = a - b;
                else if (f7 == 7'h00 && f3 == 3'd7) e_res = a & b;
                else if (f7 == 7'h00 && f3 == 3'd6) e_res = a | b;
                else if (f7 == 7'h00 && f3 == 3'd2) e_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                else if (f7 == 7'h00 && f3 == 3'd1) e_res = a << b[4:0];
                else if (f7 == 7'h00 && f3 == 3'd5) e_res = a >> b[4:0];
                else if (f7 == 7'h20 && f3 == 3'd5) e_res = $signed(a) >>> b[4:0];
                else begin e_known = 0; e_wr = 0; end
                e_wval = e_res;
            end
            7'b0010011: begin
                if (f3 == 3'd0)      begin e_known = 1; e_wr = 1; e_res = a + imm_i; end
                else if (f3 == 3'd6) begin e_known = 1; e_wr = 1; e_res = a | imm_i; end
                e_wval = e_res;
            end
            7'b0000011: if (f3 == 3'd2) begin
                e_known = 1; e_wr = 1; e_res = a + imm_i; e_wval = rdat;
            end
            7'b0100011: if (f3 == 3'd2) begin
                e_known = 1; e_we = 1; e_res = a + imm_s;
            end
            7'b1100011: if (f3 == 3'd0) begin
                e_known = 1; e_res = a - b;
                if (e_res == 0) e_npc = m_pc + imm_b;
            end
            7'b1101111: begin
                e_known = 1; e_wr = 1; e_res = imm_j;
                e_wval = m_pc + 32'd4; e_npc = m_pc + imm_j;
            end
            7'b1100111: if (f3 == 3'd0) begin
                e_known = 1; e_wr = 1; e_res = a + imm_i;
                e_wval = m_pc + 32'd4; e_npc = {e_res[31:1], 1'b0};
            end
            7'b0110111: begin
                e_known = 1; e_wr = 1; e_res = imm_u; e_wval = imm_u;
            end
            default: ;
        endcase
    endfunction

    // Present an instruction and let the combinational outputs settle
    task automatic apply(input logic [31:0] ins, input logic [31:0] rdat);
        instr    = ins;
        readData = rdat;
        model_exec(ins, rdat);
        #1;
    endtask

    // Retire the presented instruction on the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
        if (e_wr && e_rd != 5'd0) m_rf[e_rd] = e_wval;
        m_pc = e_npc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instr = 32'h0000_0013;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_pc  = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(enc_s(12'h000, 5'd1, 5'd0), 32'd0);
        n_tests++;
        if (we !== 1'b0) begin
            n_fail++; $display("FAIL reset_we: we=%b required 0", we);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_pc  = 32'd0;
        instr = 32'h0000_0013;
        #1;
        n_tests++;
        if (instrAddr !== 32'd0) begin
            n_fail++; $display("FAIL reset_pc: instrAddr=%h required 0", instrAddr);
        end
    endtask

    task automatic test_load_add();
        do_reset();
        apply(enc_i(12'h000, 5'd0, 3'b010, 5'd1, 7'b0000011), 32'hFF);
        n_tests++;
        if (instrAddr !== 32'd0 || dataAddr !== 32'd0 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL lw: instrAddr=%h dataAddr=%h we=%b required 0/0/0", instrAddr, dataAddr, we);
        end
        step();
        apply(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd1), 32'd0);
        n_tests++;
        if (result !== 32'h1FE || instrAddr !== 32'd4 || writeData !== 32'hFF) begin
            n_fail++;
            $display("FAIL add_after_lw: result=%h instrAddr=%h writeData=%h required 1fe/4/ff",
                     result, instrAddr, writeData);
        end
        step();
    endtask

    task automatic test_store();
        apply(enc_s(12'h000, 5'd1, 5'd0), 32'd0);
        n_tests++;
        if (we !== 1'b1 || dataAddr !== 32'd0 || writeData !== 32'h1FE) begin
            n_fail++;
            $display("FAIL sw: we=%b dataAddr=%h writeData=%h required 1/0/1fe", we, dataAddr, writeData);
        end
        step();
        apply(enc_i(12'h000, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'd0);
        n_tests++;
        if (we !== 1'b0) begin
            n_fail++; $display("FAIL we_non_store: we=%b required 0", we);
        end
        step();
    endtask

    task automatic test_branch();
        do_reset();
        apply(enc_i(12'h000, 5'd0, 3'b000, 5'd30, 7'b0010011), 32'd0); step();
        apply(enc_i(12'h000, 5'd0, 3'b000, 5'd31, 7'b0010011), 32'd0); step();
        apply(enc_i(12'h000, 5'd0, 3'b000, 5'd2,  7'b0010011), 32'd0); step();
        apply(enc_b(13'd12, 5'd31, 5'd30), 32'd0);
        n_tests++;
        if (instrAddr !== 32'h0C || result !== 32'd0) begin
            n_fail++; $display("FAIL beq_taken_pre: instrAddr=%h result=%h required c/0", instrAddr, result);
        end
        step();
        n_tests++;
        if (instrAddr !== 32'h18) begin
            n_fail++; $display("FAIL beq_taken_pc: instrAddr=%h required 18", instrAddr);
        end
        apply(enc_i(12'h0FF, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'd0); step();
        apply(enc_b(13'd12, 5'd0, 5'd1), 32'd0);
        n_tests++;
        if (result !== 32'hFF) begin
            n_fail++; $display("FAIL beq_not_taken_res: result=%h required ff", result);
        end
        step();
        n_tests++;
        if (instrAddr !== 32'h20) begin
            n_fail++; $display("FAIL beq_not_taken_pc: instrAddr=%h required 20", instrAddr);
        end
    endtask

    task automatic test_alu();
        logic [31:0] prog [13];
        logic [31:0] expv [13];
        do_reset();
        prog[0]  = enc_i(12'd12, 5'd0, 3'b000, 5'd1, 7'b0010011);   expv[0]  = 32'd12;
        prog[1]  = enc_i(12'd10, 5'd0, 3'b000, 5'd2, 7'b0010011);   expv[1]  = 32'd10;
        prog[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3);          expv[2]  = 32'b1000;
        prog[3]  = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3);          expv[3]  = 32'b1110;
        prog[4]  = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd3);          expv[4]  = 32'd1;
        prog[5]  = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3);          expv[5]  = 32'd0;
        prog[6]  = enc_r(7'h00, 5'd1, 5'd1, 3'b010, 5'd3);          expv[6]  = 32'd0;
        prog[7]  = enc_i(12'h0FF, 5'd0, 3'b000, 5'd4, 7'b0010011);  expv[7]  = 32'hFF;
        prog[8]  = enc_i(12'h00F, 5'd0, 3'b000, 5'd5, 7'b0010011);  expv[8]  = 32'h0F;
        prog[9]  = enc_r(7'h20, 5'd5, 5'd4, 3'b000, 5'd3);          expv[9]  = 32'hF0;
        prog[10] = enc_r(7'h00, 5'd0, 5'd3, 3'b000, 5'd6);          expv[10] = 32'hF0;
        prog[11] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd7, 7'b0010011);  expv[11] = 32'hFFFF_FFFF;
        prog[12] = enc_r(7'h00, 5'd1, 5'd7, 3'b010, 5'd3);          expv[12] = 32'd1;
        for (int i = 0; i < 13; i++) begin
            apply(prog[i], 32'd0);
            n_tests++;
            if (result !== expv[i]) begin
                n_fail++; $display("FAIL alu[%0d]: result=%h required %h", i, result, expv[i]);
            end
            step();
        end
        apply(enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'd0); step();
        apply(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd3), 32'd0);
        n_tests++;
        if (result !== 32'd0 || writeData !== 32'd0) begin
            n_fail++; $display("FAIL x0_write: result=%h writeData=%h required 0/0", result, writeData);
        end
        step();
    endtask

    task automatic test_jumps();
        do_reset();
        apply(enc_j(21'h0D0, 5'd0), 32'd0); step();
        apply(enc_j(21'h200, 5'd1), 32'd0);
        n_tests++;
        if (instrAddr !== 32'hD0 || result !== 32'h200) begin
            n_fail++; $display("FAIL jal: instrAddr=%h result=%h required d0/200", instrAddr, result);
        end
        step();
        apply(enc_r(7'h00, 5'd0, 5'd1, 3'b000, 5'd3), 32'd0);
        n_tests++;
        if (instrAddr !== 32'h2D0 || result !== 32'hD4) begin
            n_fail++; $display("FAIL jal_link: instrAddr=%h x1=%h required 2d0/d4", instrAddr, result);
        end
        step();
        apply(enc_i(12'h100, 5'd1, 3'b000, 5'd1, 7'b1100111), 32'd0);
        n_tests++;
        if (instrAddr !== 32'h2D4 || result !== 32'h1D4) begin
            n_fail++; $display("FAIL jalr: instrAddr=%h result=%h required 2d4/1d4", instrAddr, result);
        end
        step();
        apply(enc_r(7'h00, 5'd0, 5'd1, 3'b000, 5'd3), 32'd0);
        n_tests++;
        if (instrAddr !== 32'h1D4 || result !== 32'h2D8) begin
            n_fail++; $display("FAIL jalr_link: instrAddr=%h x1=%h required 1d4/2d8", instrAddr, result);
        end
        step();
    endtask

    task automatic test_upper_shift();
        logic [31:0] prog [6];
        logic [31:0] expv [6];
        do_reset();
        prog[0] = enc_u(20'hABCDE, 5'd1);                           expv[0] = 32'hABCDE000;
        prog[1] = enc_i(12'h123, 5'd1, 3'b110, 5'd1, 7'b0010011);   expv[1] = 32'hABCDE123;
        prog[2] = enc_i(12'd8, 5'd0, 3'b000, 5'd2, 7'b0010011);     expv[2] = 32'd8;
        prog[3] = enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd3);           expv[3] = 32'hFFABCDE1;
        prog[4] = enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd3);           expv[4] = 32'h00ABCDE1;
        prog[5] = enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd3);           expv[5] = 32'hCDE12300;
        for (int i = 0; i < 6; i++) begin
            apply(prog[i], 32'd0);
            n_tests++;
            if (result !== expv[i]) begin
                n_fail++; $display("FAIL upper_shift[%0d]: result=%h required %h", i, result, expv[i]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply(enc_i(12'h055, 5'd0, 3'b000, 5'd5, 7'b0010011), 32'd0); step();
        apply(enc_i(12'h010, 5'd0, 3'b000, 5'd6, 7'b0010011), 32'd0); step();
        reset = 1'b1;
        apply(enc_i(12'h077, 5'd0, 3'b000, 5'd5, 7'b0010011), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_pc  = 32'd0;
        apply(enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd3), 32'd0);
        n_tests++;
        if (instrAddr !== 32'd0 || result !== 32'h55) begin
            n_fail++;
            $display("FAIL reset_mid: instrAddr=%h x5=%h required 0/55", instrAddr, result);
        end
        step();
    endtask

    function automatic logic [31:0] gen_instr();
        int          k;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] i12;
        k   = int'($urandom_range(0, 18));
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        i12 = 12'($urandom);
        case (k)
            0:  return enc_r(7'h00, rs2, rs1, 3'b000, rd);
            1:  return enc_r(7'h20, rs2, rs1, 3'b000, rd);
            2:  return enc_r(7'h00, rs2, rs1, 3'b111, rd);
            3:  return enc_r(7'h00, rs2, rs1, 3'b110, rd);
            4:  return enc_r(7'h00, rs2, rs1, 3'b010, rd);
            5:  return enc_r(7'h00, rs2, rs1, 3'b001, rd);
            6:  return enc_r(7'h00, rs2, rs1, 3'b101, rd);
            7:  return enc_r(7'h20, rs2, rs1, 3'b101, rd);
            8:  return enc_i(i12, rs1, 3'b000, rd, 7'b0010011);
            9:  return enc_i(i12, rs1, 3'b110, rd, 7'b0010011);
            10: return enc_i(i12, rs1, 3'b010, rd, 7'b0000011);
            11: return enc_s(i12, rs2, rs1);
            12: begin
                if ($urandom_range(0, 1) == 1) rs2 = rs1;
                return enc_b({12'($urandom), 1'b0}, rs2, rs1);
            end
            13: return enc_j({20'($urandom), 1'b0}, rd);
            14: return enc_i(i12, rs1, 3'b000, rd, 7'b1100111);
            15: return enc_u(20'($urandom), rd);
            16: return enc_r(7'h01, rs2, rs1, 3'b000, rd);
            17: return enc_i(i12, rs1, 3'b100, rd, 7'b0010011);
            default: return {25'($urandom), 7'b0001111};
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] ins;
        do_reset();
        for (int r = 1; r < 32; r++) begin
            apply(enc_i(12'($urandom), 5'd0, 3'b000, 5'(r), 7'b0010011), 32'd0);
            step();
        end
        for (int n = 0; n < 400; n++) begin
            ins = gen_instr();
            apply(ins, $urandom);
            n_tests++;
            if (instrAddr !== m_pc) begin
                n_fail++; $display("FAIL rnd_pc[%0d] ins=%h: instrAddr=%h required %h", n, ins, instrAddr, m_pc);
            end
            n_tests++;
            if (we !== e_we) begin
                n_fail++; $display("FAIL rnd_we[%0d] ins=%h: we=%b required %b", n, ins, we, e_we);
            end
            n_tests++;
            if (writeData !== m_rf[ins[24:20]]) begin
                n_fail++;
                $display("FAIL rnd_wdata[%0d] ins=%h: writeData=%h required %h", n, ins, writeData, m_rf[ins[24:20]]);
            end
            if (e_known) begin
                n_tests++;
                if (result !== e_res || dataAddr !== e_res) begin
                    n_fail++;
                    $display("FAIL rnd_result[%0d] ins=%h: result=%h dataAddr=%h required %h",
                             n, ins, result, dataAddr, e_res);
                end
            end
            step();
        end
        for (int r = 0; r < 32; r++) begin
            apply(enc_r(7'h00, 5'(r), 5'd0, 3'b000, 5'd0), 32'd0);
            n_tests++;
            if (writeData !== m_rf[r]) begin
                n_fail++; $display("FAIL rf_dump x%0d: value=%h required %h", r, writeData, m_rf[r]);
            end
            step();
        end
    endtask

    initial begin
        reset    = 1'b1;
        instr    = 32'h0000_0013;
        readData = 32'd0;
        m_pc     = 32'd0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        test_reset();
        test_load_add();
        test_store();
        test_branch();
        test_alu();
        test_jumps();
        test_upper_shift();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
